timer_a_counter: RTL and testbench

- 16-bit TimerA counter core (TAR). Consumes the one-MCLK-wide timer_tick enable produced by the TimerA clock-select/pre-divider path.
- Implements MSP430 MC modes: stop, up, continuous and up/down.
- Generates the TAIFG overflow flag and the EQU0 compare pulse.
- Feeds the capture/compare channels and the TimerA interrupt logic.

---
 rtl/timer_a_counter.sv | 120 ++++++++++++
 tb/tb_timer_a_counter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_a_counter.sv
// TimerA 16-bit counter core (TAR): stop/up/continuous/up-down counting with
// TAIFG overflow flag, registered EQU0 compare pulse and count direction.
module timer_a_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             timer_tick,
  input  logic [1:0]       MC,
  input  logic [WIDTH-1:0] TACCR0,
  input  logic             wTACLR,
  input  logic             wTAR,
  input  logic [WIDTH-1:0] TAR_in,
  input  logic             TAIFG_clr,
  output logic [WIDTH-1:0] TAR,
  output logic             TAIFG,
  output logic             EQU0,
  output logic             dir_down
);

  typedef enum logic [1:0] {
    MC_STOP = 2'd0,
    MC_UP   = 2'd1,
    MC_CONT = 2'd2,
    MC_UPDN = 2'd3
  } mc_e;

  logic [WIDTH-1:0] tar_q, tar_d;
  logic             ifg_q, ifg_d;
  logic             equ0_q, equ0_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] tar_inc_c, tar_dec_c;
  logic             ccr0_zero_c, step_c, set_c;
  mc_e              mode_c;

  assign mode_c      = mc_e'(MC);
  assign tar_inc_c   = tar_q + WIDTH'(1);
  assign tar_dec_c   = tar_q - WIDTH'(1);
  assign ccr0_zero_c = (TACCR0 == '0);

  // Next-state: clear beats load beats count step; TACCR0==0 halts up/up-down.
  always_comb begin
    tar_d  = tar_q;
    dir_d  = dir_q;
    step_c = 1'b0;
    set_c  = 1'b0;
    if (mode_c == MC_UP || mode_c == MC_CONT) begin
      dir_d = 1'b0;
    end
    if (wTACLR) begin
      tar_d = '0;
      dir_d = 1'b0;
    end else if (wTAR) begin
      tar_d = TAR_in;
    end else if (timer_tick) begin
      unique case (mode_c)
        MC_UP: begin
          if (!ccr0_zero_c) begin
            step_c = 1'b1;
            if (tar_q >= TACCR0) begin
              tar_d = '0;
              set_c = 1'b1;
            end else begin
              tar_d = tar_inc_c;
            end
          end
        end
        MC_CONT: begin
          step_c = 1'b1;
          tar_d  = tar_inc_c;
          set_c  = &tar_q;
        end
        MC_UPDN: begin
          if (ccr0_zero_c) begin
            dir_d = 1'b0;
          end else if (!dir_q) begin
            step_c = 1'b1;
            if (tar_q >= TACCR0) begin
              tar_d = tar_dec_c;
              dir_d = 1'b1;
            end else begin
              tar_d = tar_inc_c;
              dir_d = (tar_inc_c == TACCR0);
            end
          end else begin
            step_c = 1'b1;
            tar_d  = tar_dec_c;
            if (tar_dec_c == '0) begin
              set_c = 1'b1;
              dir_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
    equ0_d = step_c && (tar_d == TACCR0);
    ifg_d  = set_c | (ifg_q & ~TAIFG_clr);
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      tar_q  <= '0;
      ifg_q  <= 1'b0;
      equ0_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      tar_q  <= tar_d;
      ifg_q  <= ifg_d;
      equ0_q <= equ0_d;
      dir_q  <= dir_d;
    end
  end

  assign TAR      = tar_q;
  assign TAIFG    = ifg_q;
  assign EQU0     = equ0_q;
  assign dir_down = dir_q;

endmodule

// File: tb/tb_timer_a_counter.sv
// Bench for timer_a_counter: vector table, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_timer_a_counter;

  logic        MCLK;
  logic        reset;
  logic        timer_tick;
  logic [1:0]  MC;
  logic [15:0] TACCR0;
  logic        wTACLR;
  logic        wTAR;
  logic [15:0] TAR_in;
  logic        TAIFG_clr;
  logic [15:0] TAR;
  logic        TAIFG;
  logic        EQU0;
  logic        dir_down;

  int n_tests = 0;
  int n_fail  = 0;

  timer_a_counter #(.WIDTH(16)) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .timer_tick(timer_tick),
    .MC        (MC),
    .TACCR0    (TACCR0),
    .wTACLR    (wTACLR),
    .wTAR      (wTAR),
    .TAR_in    (TAR_in),
    .TAIFG_clr (TAIFG_clr),
    .TAR       (TAR),
    .TAIFG     (TAIFG),
    .EQU0      (EQU0),
    .dir_down  (dir_down)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Reference model state, in plain integers.
  int m_tar;
  bit m_ifg, m_equ0, m_dir;

  function automatic void model_reset();
    m_tar = 0; m_ifg = 0; m_equ0 = 0; m_dir = 0;
  endfunction

  // Behaviour of one MCLK edge from the currently applied inputs.
  function automatic void model_edge();
    int  nt;
    bit  counted, wrapped;
    int  ccr;
    nt = m_tar; counted = 0; wrapped = 0; ccr = int'(TACCR0);
    if (!reset) begin
      model_reset();
      return;
    end
    if (MC == 2'd1 || MC == 2'd2) m_dir = 0;
    if (wTACLR) begin
      nt = 0; m_dir = 0;
    end else if (wTAR) begin
      nt = int'(TAR_in);
    end else if (timer_tick && MC != 2'd0) begin
      if (MC == 2'd2) begin
        counted = 1;
        nt = (m_tar + 1) % 65536;
        wrapped = (nt == 0);
      end else if (ccr == 0) begin
        m_dir = 0;
      end else if (MC == 2'd1) begin
        counted = 1;
        if (m_tar >= ccr) begin nt = 0; wrapped = 1; end
        else nt = m_tar + 1;
      end else if (!m_dir) begin
        counted = 1;
        if (m_tar >= ccr) begin nt = m_tar - 1; m_dir = 1; end
        else begin nt = m_tar + 1; m_dir = (nt == ccr); end
      end else begin
        counted = 1;
        nt = (m_tar + 65535) % 65536;
        if (nt == 0) begin wrapped = 1; m_dir = 0; end
      end
    end
    m_equ0 = counted && (nt == ccr);
    m_ifg  = wrapped || (m_ifg && !TAIFG_clr);
    m_tar  = nt;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // One MCLK edge; strobes are single-cycle so they drop after the edge.
  task automatic cyc();
    model_edge();
    @(posedge MCLK);
    #1;
    wTACLR = 0; wTAR = 0; TAIFG_clr = 0; timer_tick = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    @(posedge MCLK);
    #2;
    reset = 1;
    #1;
  endtask

  typedef struct {
    logic        clr;
    logic        wtar;
    logic [15:0] tin;
    logic        tick;
    logic [1:0]  mc;
    logic [15:0] ccr;
    logic        iclr;
    logic [15:0] e_tar;
    logic        e_ifg;
    logic        e_equ0;
    logic        e_dir;
  } vec_t;

  vec_t vecs[14];

  int exp_tar1[6];
  bit exp_ifg1[6];
  int nticks, nequ;

  initial begin
    reset = 0; timer_tick = 0; MC = 0; TACCR0 = 0;
    wTACLR = 0; wTAR = 0; TAR_in = 0; TAIFG_clr = 0;
    model_reset();

    // clr wtar tin tick mc ccr iclr | tar ifg equ0 dir
    vecs[0]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd1,      0, 0, 0};
    vecs[1]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd2,      0, 0, 0};
    vecs[2]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd3,      0, 1, 1};
    vecs[3]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd2,      0, 0, 1};
    vecs[4]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd1,      0, 0, 1};
    vecs[5]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd0,      1, 0, 0};
    vecs[6]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd3, 0, 16'd1,      1, 0, 0};
    vecs[7]  = '{0, 0, 16'h0000, 0, 2'd3, 16'd3, 1, 16'd1,      0, 0, 0};
    vecs[8]  = '{0, 1, 16'h0009, 1, 2'd3, 16'd9, 0, 16'd9,      0, 0, 0};
    vecs[9]  = '{0, 0, 16'h0000, 1, 2'd3, 16'd9, 0, 16'd8,      0, 0, 1};
    vecs[10] = '{0, 0, 16'h0000, 1, 2'd3, 16'd9, 0, 16'd7,      0, 0, 1};
    vecs[11] = '{1, 0, 16'h0000, 1, 2'd3, 16'd9, 0, 16'd0,      0, 0, 0};
    vecs[12] = '{0, 1, 16'h1234, 1, 2'd2, 16'd9, 0, 16'h1234,   0, 0, 0};
    vecs[13] = '{0, 0, 16'h0000, 1, 2'd2, 16'd9, 0, 16'h1235,   0, 0, 0};

    // Reset state
    #2;
    chk16("reset_tar", TAR, 16'h0);
    chk1("reset_ifg", TAIFG, 1'b0);
    chk1("reset_equ0", EQU0, 1'b0);
    chk1("reset_dir", dir_down, 1'b0);
    @(posedge MCLK);
    #2;
    reset = 1;
    #1;

    // Vector table: up/down period, clear/load priority over tick
    for (int i = 0; i < 14; i++) begin
      wTACLR = vecs[i].clr; wTAR = vecs[i].wtar; TAR_in = vecs[i].tin;
      timer_tick = vecs[i].tick; MC = vecs[i].mc; TACCR0 = vecs[i].ccr;
      TAIFG_clr = vecs[i].iclr;
      cyc();
      chk16($sformatf("vec%0d_tar", i), TAR, vecs[i].e_tar);
      chk1($sformatf("vec%0d_ifg", i), TAIFG, vecs[i].e_ifg);
      chk1($sformatf("vec%0d_equ0", i), EQU0, vecs[i].e_equ0);
      chk1($sformatf("vec%0d_dir", i), dir_down, vecs[i].e_dir);
    end

    // Up mode, TACCR0=4, tick every 3rd MCLK
    do_reset();
    MC = 2'd1; TACCR0 = 16'd4;
    exp_tar1 = '{1, 2, 3, 4, 0, 1};
    exp_ifg1 = '{0, 0, 0, 0, 1, 1};
    nticks = 0; nequ = 0;
    for (int i = 0; i < 18; i++) begin
      timer_tick = (i % 3 == 0);
      cyc();
      if (EQU0) nequ++;
      if (i % 3 == 0) begin
        chk16($sformatf("up_tar%0d", nticks), TAR, 16'(exp_tar1[nticks]));
        chk1($sformatf("up_ifg%0d", nticks), TAIFG, exp_ifg1[nticks]);
        chk1($sformatf("up_equ0_%0d", nticks), EQU0, nticks == 3);
        nticks++;
      end
    end
    chk16("up_equ0_count", 16'(nequ), 16'd1);

    // Up mode, TACCR0 lowered below TAR, then TACCR0=0 halts
    MC = 2'd1; TACCR0 = 16'd20; wTAR = 1; TAR_in = 16'd10; TAIFG_clr = 1;
    cyc();
    chk16("lower_load", TAR, 16'd10);
    chk1("lower_ifg0", TAIFG, 1'b0);
    TACCR0 = 16'd5; timer_tick = 1;
    cyc();
    chk16("lower_tar", TAR, 16'd0);
    chk1("lower_ifg", TAIFG, 1'b1);
    chk1("lower_equ0", EQU0, 1'b0);
    TACCR0 = 16'd0; TAIFG_clr = 1;
    cyc();
    chk1("ifgclr", TAIFG, 1'b0);
    for (int i = 0; i < 3; i++) begin
      timer_tick = 1;
      cyc();
      chk16($sformatf("halt_tar%0d", i), TAR, 16'd0);
      chk1($sformatf("halt_ifg%0d", i), TAIFG, 1'b0);
      chk1($sformatf("halt_equ0_%0d", i), EQU0, 1'b0);
    end

    // Continuous rollover; set wins over simultaneous clear
    MC = 2'd2; TACCR0 = 16'd100; wTAR = 1; TAR_in = 16'hFFFE;
    cyc();
    chk16("cont_load", TAR, 16'hFFFE);
    timer_tick = 1;
    cyc();
    chk16("cont_ffff", TAR, 16'hFFFF);
    chk1("cont_ifg0", TAIFG, 1'b0);
    timer_tick = 1; TAIFG_clr = 1;
    cyc();
    chk16("cont_wrap", TAR, 16'h0000);
    chk1("cont_set_wins", TAIFG, 1'b1);
    MC = 2'd0; timer_tick = 1;
    cyc();
    chk16("stop_hold", TAR, 16'h0000);
    chk1("stop_ifg_sticky", TAIFG, 1'b1);

    // Async reset mid-count with TAIFG and dir_down set
    MC = 2'd3; TACCR0 = 16'h0100; wTAR = 1; TAR_in = 16'h0124;
    cyc();
    timer_tick = 1;
    cyc();
    chk16("pre_rst_tar", TAR, 16'h0123);
    chk1("pre_rst_dir", dir_down, 1'b1);
    chk1("pre_rst_ifg", TAIFG, 1'b1);
    #2;
    reset = 0;
    model_reset();
    #1;
    chk16("async_rst_tar", TAR, 16'h0);
    chk1("async_rst_ifg", TAIFG, 1'b0);
    chk1("async_rst_dir", dir_down, 1'b0);
    timer_tick = 1;
    cyc();
    chk16("rst_held_tar", TAR, 16'h0);
    #2;
    reset = 1;
    timer_tick = 1;
    cyc();
    chk16("post_rst_tar", TAR, 16'h1);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) MC = 2'($urandom_range(0, 3));
      if (i % 97 == 0) begin
        case ($urandom_range(0, 3))
          0: TACCR0 = 16'd0;
          1: TACCR0 = 16'($urandom_range(1, 6));
          2: TACCR0 = 16'hFFFF;
          default: TACCR0 = 16'($urandom_range(1, 40));
        endcase
      end
      timer_tick = ($urandom_range(0, 1) == 1);
      wTACLR     = ($urandom_range(0, 60) == 0);
      wTAR       = ($urandom_range(0, 40) == 0);
      TAR_in     = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 50))
                                               : 16'($urandom_range(16'hFFF0, 16'hFFFF));
      TAIFG_clr  = ($urandom_range(0, 15) == 0);
      cyc();
      chk16("rnd_tar", TAR, 16'(m_tar));
      chk1("rnd_ifg", TAIFG, m_ifg);
      chk1("rnd_equ0", EQU0, m_equ0);
      chk1("rnd_dir", dir_down, m_dir);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
